// File: rtl/trng_postproc.sv
// Ring-oscillator post-processing: sync, decimate, von Neumann debias, pack into words,
// valid/ready output buffer, plus a repetition-count health test on the raw samples.
module trng_postproc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DECIM     = 4,
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_in,
  input  logic             en,
  input  logic             rdy,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             health_fail,
  output logic             overrun
);

  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DMAX = DW'(DECIM - 1);
  localparam logic [RW-1:0] RMAX = RW'(REP_LIMIT);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  typedef enum logic {StFirst, StSecond} vn_state_e;

  logic             r_sync1, r_sync2;
  logic [DW-1:0]    r_dcnt, w_dcnt_d;
  logic [RW-1:0]    r_rep, w_rep_d;
  logic             r_last, w_last_d;
  logic             r_health, w_health_d;
  vn_state_e        r_state, w_state_d;
  logic             r_a, w_a_d;
  // Only the low WIDTH-1 bits are kept; the incoming bit completes the word.
  logic [WIDTH-2:0] r_sreg, w_sreg_d;
  logic [BW-1:0]    r_bcnt, w_bcnt_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic             r_valid, w_valid_d;
  logic             r_overrun, w_overrun_d;

  logic             w_strobe;
  logic             w_emit;
  logic             w_done;
  logic             w_free;
  logic [WIDTH-1:0] w_word;

  always_comb begin
    w_strobe = en && (r_dcnt == DMAX);
    w_dcnt_d = r_dcnt;
    if (!en || w_strobe) begin
      w_dcnt_d = '0;
    end else begin
      w_dcnt_d = r_dcnt + DW'(1);
    end
  end

  // rep==0 marks "no sample seen since reset".
  always_comb begin
    w_rep_d    = r_rep;
    w_last_d   = r_last;
    w_health_d = r_health;
    if (w_strobe) begin
      w_last_d = r_sync2;
      if ((r_rep != '0) && (r_sync2 == r_last)) begin
        if (r_rep != RMAX) w_rep_d = r_rep + RW'(1);
      end else begin
        w_rep_d = RW'(1);
      end
      if (w_rep_d == RMAX) w_health_d = 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_emit    = 1'b0;
    if (!en) begin
      w_state_d = StFirst;
    end else if (w_strobe) begin
      unique case (r_state)
        StFirst: begin
          w_a_d     = r_sync2;
          w_state_d = StSecond;
        end
        StSecond: begin
          w_emit    = (r_sync2 != r_a);
          w_state_d = StFirst;
        end
      endcase
    end
  end

  always_comb begin
    w_word   = {r_sreg, r_a};
    w_done   = w_emit && (r_bcnt == BMAX);
    w_sreg_d = r_sreg;
    w_bcnt_d = r_bcnt;
    if (w_emit) begin
      w_sreg_d = w_word[WIDTH-2:0];
      w_bcnt_d = w_done ? '0 : r_bcnt + BW'(1);
    end
  end

  // Once health has failed, completed words are silently discarded.
  always_comb begin
    w_free      = !r_valid || rdy;
    w_data_d    = r_data;
    w_valid_d   = r_valid;
    w_overrun_d = r_overrun;
    if (r_valid && rdy) w_valid_d = 1'b0;
    if (w_done && !r_health) begin
      if (w_free) begin
        w_data_d  = w_word;
        w_valid_d = 1'b1;
      end else begin
        w_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_dcnt    <= '0;
      r_rep     <= '0;
      r_last    <= 1'b0;
      r_health  <= 1'b0;
      r_state   <= StFirst;
      r_a       <= 1'b0;
      r_sreg    <= '0;
      r_bcnt    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync1   <= raw_in;
      r_sync2   <= r_sync1;
      r_dcnt    <= w_dcnt_d;
      r_rep     <= w_rep_d;
      r_last    <= w_last_d;
      r_health  <= w_health_d;
      r_state   <= w_state_d;
      r_a       <= w_a_d;
      r_sreg    <= w_sreg_d;
      r_bcnt    <= w_bcnt_d;
      r_data    <= w_data_d;
      r_valid   <= w_valid_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign health_fail = r_health;
  assign overrun     = r_overrun;

endmodule

// File: doc/trng_postproc.md
# trng_postproc

Post-processing stage directly downstream of the ring-oscillator sampler. Synchronizes the sampler's asynchronous XOR output into the system clock domain, decimates it, removes bias with a von Neumann corrector, and packs corrected bits into WIDTH-bit words. Words are delivered through a valid/ready handshake. A repetition-count health test on the raw decimated stream flags a stuck or degenerate entropy source.

## Interface
- WIDTH, 8: output word width in bits, ≥2.
- DECIM, 4: clock cycles per raw sample taken, ≥1.
- REP_LIMIT, 32: number of consecutive identical raw samples that trips the health test, ≥2.

- clk  in  1  system clock; the single clock of the block.
- rst  in  1  asynchronous, active-high reset.
- raw_in  in  1  sampler output; asynchronous to clk.
- en  in  1  collection enable.
- rdy  in  1  consumer ready.
- data  out  WIDTH  random word; first corrected bit is the MSB.
- valid  out  1  data holds an undelivered word.
- health_fail  out  1  sticky; repetition test tripped.
- overrun  out  1  sticky; a completed word was dropped.

## Operation
- Synchronizer: two flops, sync1 then sync2. Only sync2 is used downstream.
- Decimation counter dcnt counts 0..DECIM-1 while en=1.
  - Strobe when en=1 and dcnt==DECIM-1; dcnt then wraps to 0.
  - en=0 forces dcnt to 0.
- Health test, evaluated on each strobe sample s:
  - If s equals the last strobe sample, rep increments (saturating at REP_LIMIT). Otherwise rep=1.
  - The first sample after reset sets rep=1.
  - When rep reaches REP_LIMIT, health_fail is set and stays set until rst.
- Von Neumann FSM, states FIRST and SECOND:
  - FIRST + strobe: store s in a, go to SECOND.
  - SECOND + strobe: if s≠a, emit corrected bit a; if s==a, emit nothing. Go to FIRST.
  - en=0 forces FIRST. A pending half-pair is discarded.
- Packer:
  - Each emitted bit does sreg ← {sreg[WIDTH-2:0], bit} and bcnt+1.
  - On the WIDTH-th bit, the word is complete and bcnt returns to 0.
  - sreg and bcnt are retained across en=0.
- Output buffer:
  - The buffer is free when valid=0 or rdy=1.
  - Word complete and buffer free: data ← word, valid ← 1.
  - Word complete and buffer not free: the word is dropped and overrun ← 1. data/valid are unchanged.
  - Handshake completes when valid=1 and rdy=1. valid falls next cycle unless a new word loads in the same cycle.
  - data is stable while valid=1 and rdy=0.
- With health_fail=1:
  - No new word is loaded.
  - Completed words are discarded and do not set overrun.
  - A word already in the buffer is still delivered.
- Reset values: data=0, valid=0, health_fail=0, overrun=0. Internal state: sync flops=0, dcnt=0, rep=0, FSM=FIRST, sreg=0, bcnt=0.
- Reset asserted mid-word or mid-handshake clears everything immediately. A partial word is lost.

## Timing
- raw_in reaches sync2 two clock edges after it is sampled.
- A bit emitted on the strobe in cycle T enters sreg at the edge ending T.
- If that bit completes a word and the buffer is free, valid=1 and data=word in cycle T+1.
- With raw_in alternating ideally, a word arrives every 2·WIDTH·DECIM cycles.
- health_fail rises in the cycle after the strobe at which rep reaches REP_LIMIT.
- Word completion and handshake in the same cycle: the new word loads and valid stays 1. No bubble, no drop.

## Test plan
- Reset: hold rst, toggle raw_in → data=0, valid=0, health_fail=0, overrun=0. Release rst → outputs unchanged until the first word completes.
- Word assembly: WIDTH=8, DECIM=4, rdy=1, en=1. Feed raw pairs 10,01,10,10,01,01,10,01, each sample held DECIM cycles and aligned for the 2-cycle sync → data=8'hB2, valid high exactly 1 cycle.
- Discards: pairs 00,11 interleaved with the pattern above → same 8'hB2, delayed by the discarded pairs.
- Backpressure: rdy=0 through two word completions → first word held stable with valid=1, second dropped, overrun=1. Then rdy=1 → first word delivered, valid falls.
- Health: raw_in stuck at 1 for REP_LIMIT=32 strobes → health_fail=1 after the 32nd strobe, no valid ever. Stuck for only 31 strobes, then 0 → health_fail stays 0.
- en/reset mid-operation:
  - en dropped while FSM=SECOND → half-pair discarded, bcnt preserved.
  - rst pulsed with 5 bits packed and valid=1 → all cleared, valid=0 the same cycle.
  - Next word after rst needs a full 8 corrected bits.
